// File: rtl/rgb_dimmer_if.sv
// Upstream sample channel for rgb_dimmer: r/g/b duty request plus brightness,
// transferred with a valid/ready handshake.
interface rgb_dimmer_if;
  logic [7:0] r_in;
  logic [7:0] g_in;
  logic [7:0] b_in;
  logic [7:0] brightness;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output r_in, g_in, b_in, brightness, in_valid,
    input  in_ready
  );

  modport slave (
    input  r_in, g_in, b_in, brightness, in_valid,
    output in_ready
  );
endinterface

// File: rtl/rgb_dimmer.sv
// Brightness scaler for three PWM channels using one serial shift-add multiplier;
// results commit only on period_sync. Optional square-law gamma: define GAMMA_EN.
module rgb_dimmer #(
  parameter int MUL_STEPS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  rgb_dimmer_if.slave bus,
  input  logic       period_sync,
  output logic [7:0] r_duty,
  output logic [7:0] g_duty,
  output logic [7:0] b_duty,
  output logic       updated
);

  typedef enum logic [2:0] {
    IDLE,
    MUL_R,
    MUL_G,
    MUL_B,
    WAIT_SYNC
`ifdef GAMMA_EN
    ,
    GAMMA_R,
    GAMMA_G,
    GAMMA_B
`endif
  } state_t;

  state_t      state, state_next;
  logic        ready_en;
  logic        transfer;

  logic [7:0]  g_cap, b_cap;
  logic [8:0]  bri_m;
  logic [7:0]  r_sh, g_sh, b_sh;

  logic [16:0] acc, acc_next, mcand;
  logic [7:0]  mplier;
  logic [2:0]  step;
  logic        step_done;
  logic        mul_active;
  logic [7:0]  pass_res;

  logic        load;
  logic [7:0]  load_x;
  logic [8:0]  load_m;

  // ready_en keeps in_ready low while reset is held and for no longer than one clock after
  assign bus.in_ready = ready_en && (state == IDLE);
  assign transfer     = bus.in_valid && bus.in_ready;

  assign step_done  = (step == 3'(MUL_STEPS - 1));
  assign mul_active = (state != IDLE) && (state != WAIT_SYNC);
  assign acc_next   = acc + (mplier[0] ? mcand : 17'd0);
  assign pass_res   = acc_next[15:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ready_en <= 1'b0;
    end else begin
      state    <= state_next;
      ready_en <= 1'b1;
    end
  end

  // Each pass that finishes also loads the operands of the following pass
  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_x     = 8'd0;
    load_m     = 9'd0;
    case (state)
      IDLE: begin
        if (transfer) begin
          load   = 1'b1;
          load_x = bus.r_in;
`ifdef GAMMA_EN
          state_next = GAMMA_R;
          load_m     = {1'b0, bus.r_in} + 9'd1;
`else
          state_next = MUL_R;
          load_m     = {1'b0, bus.brightness} + 9'd1;
`endif
        end
      end
`ifdef GAMMA_EN
      GAMMA_R: begin
        if (step_done) begin
          state_next = MUL_R;
          load       = 1'b1;
          load_x     = pass_res;
          load_m     = bri_m;
        end
      end
      GAMMA_G: begin
        if (step_done) begin
          state_next = MUL_G;
          load       = 1'b1;
          load_x     = pass_res;
          load_m     = bri_m;
        end
      end
      GAMMA_B: begin
        if (step_done) begin
          state_next = MUL_B;
          load       = 1'b1;
          load_x     = pass_res;
          load_m     = bri_m;
        end
      end
`endif
      MUL_R: begin
        if (step_done) begin
          load   = 1'b1;
          load_x = g_cap;
`ifdef GAMMA_EN
          state_next = GAMMA_G;
          load_m     = {1'b0, g_cap} + 9'd1;
`else
          state_next = MUL_G;
          load_m     = bri_m;
`endif
        end
      end
      MUL_G: begin
        if (step_done) begin
          load   = 1'b1;
          load_x = b_cap;
`ifdef GAMMA_EN
          state_next = GAMMA_B;
          load_m     = {1'b0, b_cap} + 9'd1;
`else
          state_next = MUL_B;
          load_m     = bri_m;
`endif
        end
      end
      MUL_B: begin
        if (step_done) state_next = WAIT_SYNC;
      end
      WAIT_SYNC: begin
        if (period_sync) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= 17'd0;
      mcand  <= 17'd0;
      mplier <= 8'd0;
      step   <= 3'd0;
    end else if (load) begin
      acc    <= 17'd0;
      mcand  <= {8'd0, load_m};
      mplier <= load_x;
      step   <= 3'd0;
    end else if (mul_active) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      step   <= step + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_cap <= 8'd0;
      b_cap <= 8'd0;
      bri_m <= 9'd0;
      r_sh  <= 8'd0;
      g_sh  <= 8'd0;
      b_sh  <= 8'd0;
    end else begin
      if (transfer) begin
        g_cap <= bus.g_in;
        b_cap <= bus.b_in;
        bri_m <= {1'b0, bus.brightness} + 9'd1;
      end
      if (step_done && state == MUL_R) r_sh <= pass_res;
      if (step_done && state == MUL_G) g_sh <= pass_res;
      if (step_done && state == MUL_B) b_sh <= pass_res;
    end
  end

  // Duties change only here, so the PWM always sees a whole period at one value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty  <= 8'd0;
      g_duty  <= 8'd0;
      b_duty  <= 8'd0;
      updated <= 1'b0;
    end else if (state == WAIT_SYNC && period_sync) begin
      r_duty  <= r_sh;
      g_duty  <= g_sh;
      b_duty  <= b_sh;
      updated <= 1'b1;
    end else begin
      updated <= 1'b0;
    end
  end

endmodule
